// File: rtl/mul_arbiter_pkg.sv
// Shared types and widths for the multiplier arbiter slice.
// FSM encoding is shared so the top and any debug logic agree on state values.
package mul_arb_pkg;
    localparam int MUL_W = 32;
    localparam int RES_W = 64;
    localparam int SEL_W = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        START = 3'd2,
        BUSY  = 3'd3,
        RESP  = 3'd4
    } arb_state_t;
endpackage

// File: rtl/mul_arbiter_if.sv
// Requester and multiplier-side signals of the arbiter.
// slave = arbiter view, master = requesters plus multiplier.
interface mul_arbiter_if
    import mul_arb_pkg::*;
#(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [MUL_W*NREQ-1:0] req_a;
    logic [MUL_W*NREQ-1:0] req_b;
    logic [SEL_W*NREQ-1:0] req_sel;
    logic [NREQ-1:0]       resp_valid;
    logic [NREQ-1:0]       resp_ready;
    logic [RES_W-1:0]      resp_result;
    logic                  resp_err;
    logic [MUL_W-1:0]      mul_a;
    logic [MUL_W-1:0]      mul_b;
    logic [SEL_W-1:0]      mul_sel;
    logic                  mul_wstrb;
    logic [RES_W-1:0]      mul_result;
    logic                  mul_rbusy;

    modport slave (
        input  req_valid, req_a, req_b, req_sel, resp_ready, mul_result, mul_rbusy,
        output req_ready, resp_valid, resp_result, resp_err, mul_a, mul_b, mul_sel, mul_wstrb
    );

    modport master (
        output req_valid, req_a, req_b, req_sel, resp_ready, mul_result, mul_rbusy,
        input  req_ready, resp_valid, resp_result, resp_err, mul_a, mul_b, mul_sel, mul_wstrb
    );
endinterface

// File: rtl/mul_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping mod NREQ.
module rr_pick #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    found
);
    localparam int IDX_W = $clog2(NREQ);

    logic [IDX_W:0]   pos;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = {1'b0, ptr} + (IDX_W+1)'(k);
            if (pos >= (IDX_W+1)'(NREQ)) pos = pos - (IDX_W+1)'(NREQ);
            cand = pos[IDX_W-1:0];
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end
endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one multiplier among NREQ requesters, one op in flight.
// Optional rbusy watchdog enabled by defining MULARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a request; grant + operand capture happen here
// ISSUE | mul_wstrb pulse
// START | waiting up to START_WIN cycles for rbusy to rise
// BUSY  | waiting for rbusy to fall
// RESP  | result presented to owner until its resp_ready
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int START_WIN   = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic         clk,
    input  logic         reset,
    mul_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NREQ);
    localparam int WIN_W = (START_WIN < 1) ? 1 : $clog2(START_WIN + 1);

    if (NREQ < 2 || NREQ > 8 || START_WIN < 0 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("mul_arbiter: unsupported parameter set");
    end

    arb_state_t       state, state_nx;
    logic [IDX_W-1:0] owner, rr_ptr, gnt_idx;
    logic [NREQ-1:0]  gnt_oh, req_ready_c;
    logic             gnt_any, can_grant, capture, timeout, tmo_hit;
    logic [WIN_W-1:0] win_cnt;
    logic [MUL_W-1:0] a_sel, b_sel, mul_a_q, mul_b_q;
    logic [SEL_W-1:0] sel_sel, mul_sel_q;
    logic [RES_W-1:0] res_q;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .gnt   (gnt_oh),
        .idx   (gnt_idx),
        .found (gnt_any)
    );

    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        sel_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                a_sel   = bus.req_a[i*MUL_W +: MUL_W];
                b_sel   = bus.req_b[i*MUL_W +: MUL_W];
                sel_sel = bus.req_sel[i*SEL_W +: SEL_W];
            end
        end
    end

`ifdef MULARB_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == ISSUE)
                tmo_cnt <= TMO_W'(TIMEOUT_CYC - 1);
            else if ((state == START || state == BUSY) && tmo_cnt != '0)
                tmo_cnt <= tmo_cnt - 1'b1;
            if (capture)
                err_q <= 1'b0;
            else if (timeout)
                err_q <= 1'b1;
        end
    end

    assign tmo_hit      = (state == START || state == BUSY) && (tmo_cnt == '0);
    // an aborted op may leave the multiplier busy; never start on top of it
    assign can_grant    = !bus.mul_rbusy;
    assign bus.resp_err = err_q;
`else
    assign tmo_hit      = 1'b0;
    assign can_grant    = 1'b1;
    assign bus.resp_err = 1'b0;
`endif

    always_comb begin
        state_nx    = state;
        req_ready_c = '0;
        capture     = 1'b0;
        timeout     = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_any && can_grant) begin
                    req_ready_c = gnt_oh;
                    state_nx    = ISSUE;
                end
            end
            ISSUE: state_nx = START;
            START: begin
                if (!bus.mul_rbusy && win_cnt == '0) begin
                    capture  = 1'b1;
                    state_nx = RESP;
                end else if (tmo_hit) begin
                    timeout  = 1'b1;
                    state_nx = RESP;
                end else if (bus.mul_rbusy) begin
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (!bus.mul_rbusy) begin
                    capture  = 1'b1;
                    state_nx = RESP;
                end else if (tmo_hit) begin
                    timeout  = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: if (bus.resp_ready[owner]) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            win_cnt   <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            mul_sel_q <= '0;
            res_q     <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx == ISSUE) begin
                owner     <= gnt_idx;
                mul_a_q   <= a_sel;
                mul_b_q   <= b_sel;
                mul_sel_q <= sel_sel;
            end
            if (state == ISSUE)
                win_cnt <= WIN_W'(START_WIN);
            else if (state == START && win_cnt != '0)
                win_cnt <= win_cnt - 1'b1;
            if (capture)
                res_q <= bus.mul_result;
            else if (timeout)
                res_q <= '1;
            if (state == RESP && state_nx == IDLE)
                rr_ptr <= (owner == IDX_W'(NREQ - 1)) ? '0 : owner + 1'b1;
        end
    end

    // req_ready is combinational from req_valid, so mask it while reset is held
    assign bus.req_ready   = req_ready_c & {NREQ{reset}};
    assign bus.resp_valid  = (state == RESP) ? (NREQ'(1) << owner) : '0;
    assign bus.resp_result = res_q;
    assign bus.mul_a       = mul_a_q;
    assign bus.mul_b       = mul_b_q;
    assign bus.mul_sel     = mul_sel_q;
    assign bus.mul_wstrb   = (state == ISSUE);
endmodule

// File: tb/tb_mul_arbiter.sv
// Randomized bench for mul_arbiter against a transaction-level round-robin model.
// Multiplier stand-in returns a*b+sel after a chosen number of busy cycles.
module tb_mul_arbiter;
    import mul_arb_pkg::*;

    localparam int NREQ        = 2;
    localparam int START_WIN   = 2;
    localparam int TIMEOUT_CYC = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mul_arbiter_if #(.NREQ(NREQ)) bus();

    mul_arbiter #(
        .NREQ(NREQ), .START_WIN(START_WIN), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // multiplier stand-in: lat>0 busy cycles, 0 = single-cycle, <0 = stuck busy
    int          mul_lat = 0;
    bit          mul_unstick = 1'b0;
    int          mcnt;
    logic [63:0] mprod;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.mul_rbusy  <= 1'b0;
            bus.mul_result <= '0;
            mcnt           <= 0;
            mprod          <= '0;
        end else if (bus.mul_wstrb) begin
            mprod <= {32'b0, bus.mul_a} * {32'b0, bus.mul_b} + 64'(bus.mul_sel);
            if (mul_lat == 0) begin
                bus.mul_result <= {32'b0, bus.mul_a} * {32'b0, bus.mul_b} + 64'(bus.mul_sel);
                bus.mul_rbusy  <= 1'b0;
            end else begin
                bus.mul_result <= {$urandom, $urandom};
                bus.mul_rbusy  <= 1'b1;
                mcnt           <= (mul_lat < 0) ? -1 : mul_lat;
            end
        end else if (mcnt > 0) begin
            if (mcnt == 1) begin
                bus.mul_rbusy  <= 1'b0;
                bus.mul_result <= mprod;
            end
            mcnt <= mcnt - 1;
        end else if (mcnt < 0 && mul_unstick) begin
            bus.mul_rbusy <= 1'b0;
            mcnt          <= 0;
        end
    end

    // reference model state
    logic [NREQ-1:0] rv;
    logic [31:0]     a_q [NREQ];
    logic [31:0]     b_q [NREQ];
    logic [1:0]      s_q [NREQ];
    bit              busy;
    int              owner_m, rr_m, g_cyc, resp_cyc, cyc;
    logic [31:0]     ea, eb;
    logic [1:0]      es;
    logic [63:0]     exp_res;
    bit              exp_err;
    int              p_new, p_ack, p_drop, lat_force;
    bit              ack_block;

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic load_op(input int i);
        a_q[i] = $urandom;
        b_q[i] = $urandom;
        s_q[i] = 2'($urandom_range(0, 3));
        rv[i]  = 1'b1;
    endtask

    task automatic step();
        logic [NREQ-1:0] exp_rdy, exp_vld, rdy_d;
        int g, lat;
        bit grant_ok;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (!rv[i] && $urandom_range(0, 99) < p_new) load_op(i);
            else if (rv[i] && $urandom_range(0, 99) < p_drop) rv[i] = 1'b0;
        end
        bus.req_valid = rv;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*32 +: 32] = a_q[i];
            bus.req_b[i*32 +: 32] = b_q[i];
            bus.req_sel[i*2 +: 2] = s_q[i];
            rdy_d[i] = ($urandom_range(0, 99) < p_ack);
        end
        if (ack_block) rdy_d[owner_m] = 1'b0;
        bus.resp_ready = rdy_d;
        #1;
`ifdef MULARB_TIMEOUT_EN
        grant_ok = !bus.mul_rbusy;
`else
        grant_ok = 1'b1;
`endif
        exp_rdy = '0;
        g = -1;
        if (!busy && rv != '0 && grant_ok) begin
            g = pick(rv, rr_m);
            exp_rdy[g] = 1'b1;
        end
        check("req_ready", bus.req_ready, exp_rdy);
        if (g >= 0) begin
            busy    = 1'b1;
            owner_m = g;
            g_cyc   = cyc;
            ea = a_q[g]; eb = b_q[g]; es = s_q[g];
            lat     = (lat_force > -2) ? lat_force : $urandom_range(0, 5);
            mul_lat = lat;
            if (lat < 0) begin
                resp_cyc = cyc + 2 + TIMEOUT_CYC;
                exp_res  = '1;
                exp_err  = 1'b1;
            end else begin
                resp_cyc = cyc + 3 + ((lat == 0) ? START_WIN : lat);
                exp_res  = {32'b0, ea} * {32'b0, eb} + 64'(es);
                exp_err  = 1'b0;
            end
            rv[g] = 1'b0;
        end
        check("mul_wstrb", bus.mul_wstrb, busy && cyc == g_cyc + 1);
        if (busy && cyc == g_cyc + 1) begin
            check("mul_a", bus.mul_a, ea);
            check("mul_b", bus.mul_b, eb);
            check("mul_sel", bus.mul_sel, es);
        end
        exp_vld = '0;
        if (busy && cyc >= resp_cyc) exp_vld[owner_m] = 1'b1;
        check("resp_valid", bus.resp_valid, exp_vld);
        if (exp_vld != '0) begin
            check("resp_result", bus.resp_result, exp_res);
            check("resp_err", bus.resp_err, exp_err);
            if (rdy_d[owner_m]) begin
                busy = 1'b0;
                rr_m = (owner_m + 1) % NREQ;
            end
        end
        cyc++;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((busy || rv != '0) && n < maxc) begin
            step();
            n++;
        end
        if (busy || rv != '0) check("idle_wait", 64'd0, 64'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", bus.req_ready, '0);
        check("rst_resp_valid", bus.resp_valid, '0);
        check("rst_resp_result", bus.resp_result, '0);
        check("rst_resp_err", bus.resp_err, '0);
        check("rst_mul_a", bus.mul_a, '0);
        check("rst_mul_b", bus.mul_b, '0);
        check("rst_mul_sel", bus.mul_sel, '0);
        check("rst_mul_wstrb", bus.mul_wstrb, '0);
    endtask

    initial begin
        rv = '0; busy = 1'b0; owner_m = 0; rr_m = 0; g_cyc = -10; resp_cyc = 0; cyc = 0;
        ea = '0; eb = '0; es = '0; exp_res = '0; exp_err = 1'b0;
        p_new = 0; p_ack = 100; p_drop = 0; lat_force = -2; ack_block = 1'b0;
        for (int i = 0; i < NREQ; i++) begin a_q[i] = '0; b_q[i] = '0; s_q[i] = '0; end
        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_sel = '0; bus.resp_ready = '0;
        #12;
        check_reset_outputs();
        @(posedge clk); #2 reset = 1'b1;

        // contention from rr_ptr=0: 0 then 1
        load_op(0); load_op(1); lat_force = 3;
        wait_idle(60);

        // A=7 B=6 sel=0, four busy cycles
        a_q[0] = 32'd7; b_q[0] = 32'd6; s_q[0] = 2'd0; rv[0] = 1'b1; lat_force = 4;
        wait_idle(40);

        // contention after owner 0: requester 1 goes first
        load_op(0); load_op(1); lat_force = -2;
        wait_idle(60);

        // single-cycle multiplier
        lat_force = 0; load_op(1);
        wait_idle(40);

        // consumer stalls with another request waiting
        lat_force = 2; ack_block = 1'b1; load_op(0); load_op(1);
        repeat (16) step();
        ack_block = 1'b0;
        wait_idle(60);

        // reset in BUSY with requester 1 pending
        lat_force = 5; load_op(0);
        step();
        load_op(1);
        repeat (4) step();
        #2 reset = 1'b0;
        #1;
        check_reset_outputs();
        busy = 1'b0; rr_m = 0;
        @(posedge clk); @(posedge clk); #2 reset = 1'b1;
        lat_force = -2;
        wait_idle(40);

`ifdef MULARB_TIMEOUT_EN
        lat_force = -1; load_op(0);
        wait_idle(60);
        lat_force = 2; load_op(1);
        repeat (5) step();
        mul_unstick = 1'b1;
        wait_idle(40);
        mul_unstick = 1'b0;
        lat_force = -2;
`endif

        p_new = 30; p_ack = 60; p_drop = 3;
        repeat (400) step();
        p_new = 0; p_ack = 100; p_drop = 0;
        wait_idle(200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
